sprite_sdr_bridge: RTL
======================

# sprite_sdr_bridge

Bridges the sprite renderer's row-fetch requests onto one SDRAM controller read channel. It runs entirely in the `clk_ram` domain and sits between the sprite renderer and the SDRAM controller. Each request is an 8-byte-aligned address. The block issues a 4-word × 16-bit burst read, assembles the 64-bit bitplane word and returns it with a ready pulse. It also turns the renderer's idle-slot hint into controller refresh requests, queues one request that arrives while busy, and recovers from a stalled controller with a timeout.

## Interface
Parameters:
- `TIMEOUT`, default 63: `clk_ram` cycles allowed after `ram_ack` before the burst is abandoned (range 4..255).

Ports:
- `clk_ram`  in  1  clock, all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  1  renderer request level. Only a rising edge starts a fetch.
- `addr`  in  25  byte address, sampled on the `req` rising edge. `addr[2:0]` is ignored.
- `refresh_hint`  in  1  renderer reports an idle slot, so a refresh is permitted.
- `data`  out  64  assembled bitplanes; held until the next completion.
- `rdy`  out  1  one-cycle pulse when `data` has been updated.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  sticky; set on timeout or queue overflow; cleared only by reset.
- `ram_addr`  out  25  burst start address, `{addr[24:3],3'b000}`.
- `ram_rd`  out  1  read request; held until `ram_ack` is sampled.
- `ram_refresh`  out  1  refresh request; held until `ram_ack` is sampled.
- `ram_ack`  in  1  controller accepted the current `ram_rd` or `ram_refresh`.
- `ram_valid`  in  1  a burst word is present on `ram_data`.
- `ram_data`  in  16  burst word.

## Operation
- Edge detection:
  - Registered `req_d`; `req_edge = req & ~req_d`.
  - A level held for many cycles produces one fetch.
- Pending slot (depth 1):
  - When `req_edge` occurs outside IDLE, `addr` is latched into the pending slot.
  - A `req_edge` while the slot is already full is dropped and sets `err`.
- State machine:
  - **IDLE:**
    - `req_edge` or a full pending slot → REQ. A new edge has priority over the pending slot; the older pending entry is then served next.
    - Otherwise, `refresh_hint` → REFRESH.
  - **REQ:** `ram_rd`=1 and `ram_addr` stable. When `ram_ack` is sampled: clear the word counter and timeout counter → WAIT_DATA.
  - **WAIT_DATA:**
    - Each `ram_valid` writes `ram_data` into `data_sr[16k+15:16k]`, where k is the 2-bit word counter, then increments k.
    - When the valid for k=3 arrives → DONE.
    - If the timeout counter reaches `TIMEOUT` → DONE with `data_sr` forced to 0 and `err` set.
  - **DONE:**
    - `data <= data_sr`, `rdy`=1 for this cycle.
    - A full pending slot → REQ with `ram_addr` taken from the slot, and the slot is cleared. Otherwise → IDLE.
  - **REFRESH:** `ram_refresh`=1. When `ram_ack` is sampled → IDLE. Request edges arriving here go to the pending slot.
- `ram_valid` outside WAIT_DATA is ignored. This covers stray words after a timeout or reset.
- Word order is little-endian: word 0 → `data[15:0]`.

## Timing
- Reset values:
  - `data`=0, `rdy`=0, `busy`=0, `err`=0.
  - `ram_rd`=0, `ram_refresh`=0, `ram_addr`=0.
  - `req_d`=0, pending slot empty, state IDLE.
- Reset mid-burst aborts immediately. No `rdy` is produced for the aborted burst.
- Request path:
  - `req_edge` at cycle n → `ram_rd`=1 from n+1.
  - `ram_rd` falls the cycle after `ram_ack` is sampled.
- Data path:
  - 4th `ram_valid` at cycle m → `rdy`=1 and new `data` at m+1.
  - Minimum latency (ack at n+1, valids at n+2..n+5): `rdy` at n+6.
- Back-to-back: with a full pending slot, `ram_rd` re-asserts at m+2.
- `ram_ack` and `ram_valid` in the same cycle while in REQ: the valid is ignored. The controller must not send data before acking.
- `req_edge` in the same cycle as DONE: the edge is latched into the pending slot. It is served immediately only if the slot was empty; otherwise it overflows.
- `refresh_hint` is only honoured in IDLE with the pending slot empty.
- Timeout counter counts WAIT_DATA cycles from the ack. The abort happens on the cycle the count equals `TIMEOUT`, even if valid words are still arriving.

## Test plan
- Single fetch:
  - Stimulus: `addr`=0x0123457, ack at n+1, words 0x1111/0x2222/0x3333/0x4444 at n+2..n+5.
  - Response: `ram_addr`=0x0123450, `data`=0x4444_3333_2222_1111, `rdy` high only at n+6.
- Held `req`: `req` high for 10 cycles → exactly one `ram_rd` assertion and one `rdy`.
- Queueing and overflow:
  - A second edge (addr 0x200) during WAIT_DATA → after the first `rdy`, `ram_rd` re-asserts with `ram_addr`=0x200, `err` stays 0.
  - A third edge while the slot is full → dropped and `err`=1.
- Refresh:
  - `refresh_hint`=1 in IDLE → `ram_refresh` held until ack, then IDLE.
  - A `req_edge` during REFRESH → served right after the refresh ack.
- Timeout: `TIMEOUT`=8, ack given, only 2 valids → `rdy` 9 cycles after the ack with `data`=0, `err`=1. Later stray valids do not change `data`.
- Reset mid-burst: reset after the 2nd valid → all outputs at reset values, no `rdy`, and the next request completes normally.

Source files
------------

// File: rtl/sprite_sdr_bridge.sv
// Sprite row-fetch to SDRAM read-channel bridge: one 4x16-bit burst per request,
// a depth-1 pending slot, refresh requests from idle hints and a stall timeout.
module sprite_sdr_bridge #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk_ram,
  input  logic        reset,
  input  logic        req,
  input  logic [24:0] addr,
  input  logic        refresh_hint,
  output logic [63:0] data,
  output logic        rdy,
  output logic        busy,
  output logic        err,
  output logic [24:0] ram_addr,
  output logic        ram_rd,
  output logic        ram_refresh,
  input  logic        ram_ack,
  input  logic        ram_valid,
  input  logic [15:0] ram_data,
  output logic [2:0]  dbg_state
);

  // Handshake: ram_rd / ram_refresh are held high until a cycle in which
  // ram_ack is sampled high; ram_valid only counts while waiting for data.

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_DONE    = 3'd3,
    ST_REFRESH = 3'd4
  } state_e;

  localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

  state_e      state_q;
  logic        req_q;
  logic        pend_v_q;
  logic [21:0] pend_addr_q;
  logic [1:0]  word_q;
  logic [7:0]  tcnt_q;
  logic [63:0] data_sr_q;
  logic [63:0] data_q;
  logic        rdy_q;
  logic        err_q;
  logic [24:0] ram_addr_q;
  logic        ram_rd_q;
  logic        ram_refresh_q;

  logic        req_edge;
  logic [24:0] line_addr;
  logic [24:0] pend_line_addr;
  logic [63:0] sr_ins;
  logic        timeout_hit;
  logic        capture_ok;

  assign req_edge       = req & ~req_q;
  assign line_addr      = {addr[24:3], 3'b000};
  assign pend_line_addr = {pend_addr_q, 3'b000};
  // The abort fires on the WAIT cycle whose count reaches TIMEOUT.
  assign timeout_hit    = ({1'b0, tcnt_q} + 9'd1) == TO_LIM;
  // IDLE and DONE decide for themselves what to do with a fresh edge.
  assign capture_ok     = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                          (state_q == ST_REFRESH);

  always_comb begin
    sr_ins = data_sr_q;
    case (word_q)
      2'd0:    sr_ins[15:0]  = ram_data;
      2'd1:    sr_ins[31:16] = ram_data;
      2'd2:    sr_ins[47:32] = ram_data;
      default: sr_ins[63:48] = ram_data;
    endcase
  end

  always_ff @(posedge clk_ram) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_q         <= 1'b0;
      pend_v_q      <= 1'b0;
      pend_addr_q   <= '0;
      word_q        <= '0;
      tcnt_q        <= '0;
      data_sr_q     <= '0;
      data_q        <= '0;
      rdy_q         <= 1'b0;
      err_q         <= 1'b0;
      ram_addr_q    <= '0;
      ram_rd_q      <= 1'b0;
      ram_refresh_q <= 1'b0;
    end else begin
      req_q <= req;
      rdy_q <= 1'b0;

      if (capture_ok && req_edge) begin
        if (pend_v_q) begin
          err_q <= 1'b1;
        end else begin
          pend_v_q    <= 1'b1;
          pend_addr_q <= addr[24:3];
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (req_edge) begin
            state_q    <= ST_REQ;
            ram_rd_q   <= 1'b1;
            ram_addr_q <= line_addr;
          end else if (pend_v_q) begin
            state_q    <= ST_REQ;
            ram_rd_q   <= 1'b1;
            ram_addr_q <= pend_line_addr;
            pend_v_q   <= 1'b0;
          end else if (refresh_hint) begin
            state_q       <= ST_REFRESH;
            ram_refresh_q <= 1'b1;
          end
        end

        ST_REQ: begin
          if (ram_ack) begin
            state_q  <= ST_WAIT;
            ram_rd_q <= 1'b0;
            word_q   <= '0;
            tcnt_q   <= '0;
          end
        end

        ST_WAIT: begin
          if (timeout_hit) begin
            state_q   <= ST_DONE;
            data_sr_q <= '0;
            data_q    <= '0;
            rdy_q     <= 1'b1;
            err_q     <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
            if (ram_valid) begin
              data_sr_q <= sr_ins;
              word_q    <= word_q + 2'd1;
              if (word_q == 2'd3) begin
                state_q <= ST_DONE;
                data_q  <= sr_ins;
                rdy_q   <= 1'b1;
              end
            end
          end
        end

        ST_DONE: begin
          // An older queued address goes first; a same-cycle edge then overflows.
          if (pend_v_q) begin
            state_q    <= ST_REQ;
            ram_rd_q   <= 1'b1;
            ram_addr_q <= pend_line_addr;
            pend_v_q   <= 1'b0;
            if (req_edge) begin
              err_q <= 1'b1;
            end
          end else if (req_edge) begin
            state_q    <= ST_REQ;
            ram_rd_q   <= 1'b1;
            ram_addr_q <= line_addr;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_REFRESH: begin
          if (ram_ack) begin
            state_q       <= ST_IDLE;
            ram_refresh_q <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign data        = data_q;
  assign rdy         = rdy_q;
  assign busy        = (state_q != ST_IDLE);
  assign err         = err_q;
  assign ram_addr    = ram_addr_q;
  assign ram_rd      = ram_rd_q;
  assign ram_refresh = ram_refresh_q;
  assign dbg_state   = state_q;

endmodule
